// File: rtl/vga_timing_generator_pkg.sv
// Shared VGA timing constants, types and helpers for the timing generator and image generator.
package vga_timing_generator_pkg;

    // Frame geometry shared with the image generator.
    localparam int unsigned FRAME_WIDTH  = 640;
    localparam int unsigned FRAME_HEIGHT = 480;

    // 640x480@60 Hz line and frame timing.
    localparam int unsigned H_VISIBLE_DEF = FRAME_WIDTH;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;
    localparam int unsigned V_VISIBLE_DEF = FRAME_HEIGHT;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;

    localparam int unsigned CNT_W = 12;
    typedef logic [CNT_W-1:0] cnt_t;

    // Delay-line bit order is {active, hsync_n, vsync_n}; idle is blanked with both syncs high.
    localparam logic [2:0] SYNC_IDLE = 3'b011;

    // True when cnt lies in [start, start+len).
    function automatic logic in_window(cnt_t cnt, cnt_t start, cnt_t len);
        return (cnt >= start) && (cnt < start + len);
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Shift register that delays {active, hsync_n, vsync_n} so the sync pins line up with RGB.
module vga_sync_delay
    import vga_timing_generator_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [2:0] sync_i,
    output logic [2:0] sync_pre_o,
    output logic [2:0] sync_o
);

    logic [2:0] stage_q [Depth];
    logic [2:0] stage_d [Depth];

    // Each stage takes the previous one; stage 0 takes the input.
    always_comb begin
        stage_d[0] = sync_i;
        for (int unsigned i = 1; i < Depth; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Shift on every clock; reset clears all stages to the idle pattern.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                stage_q[i] <= SYNC_IDLE;
            end
        end else begin
            for (int unsigned i = 0; i < Depth; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    // Value about to enter the last stage: lets the RGB register gate colour on the same edge.
    assign sync_pre_o = stage_d[Depth-1];
    assign sync_o     = stage_q[Depth-1];

endmodule

// File: rtl/vga_timing_generator.sv
// 640x480@60 Hz VGA timing: presents 1-based x/y, registers blank-masked colour and syncs.
module vga_timing_generator
    import vga_timing_generator_pkg::*;
#(
    parameter int unsigned H_VISIBLE     = H_VISIBLE_DEF,
    parameter int unsigned H_FRONT       = H_FRONT_DEF,
    parameter int unsigned H_SYNC        = H_SYNC_DEF,
    parameter int unsigned H_BACK        = H_BACK_DEF,
    parameter int unsigned V_VISIBLE     = V_VISIBLE_DEF,
    parameter int unsigned V_FRONT       = V_FRONT_DEF,
    parameter int unsigned V_SYNC        = V_SYNC_DEF,
    parameter int unsigned V_BACK        = V_BACK_DEF,
    parameter int unsigned COLOR_LATENCY = 1
) (
    input  logic        CLOCK_25,
    input  logic        RESET_N,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        active,
    input  logic [2:0]  color,
    output logic [2:0]  vga_rgb,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_blank_n,
    output logic        frame_tick,
    output logic [15:0] frame_count
);

    localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned Depth  = COLOR_LATENCY + 1;

    localparam cnt_t HLast      = cnt_t'(HTotal - 1);
    localparam cnt_t VLast      = cnt_t'(VTotal - 1);
    localparam cnt_t HVis       = cnt_t'(H_VISIBLE);
    localparam cnt_t VVis       = cnt_t'(V_VISIBLE);
    localparam cnt_t HSyncStart = cnt_t'(H_VISIBLE + H_FRONT);
    localparam cnt_t HSyncLen   = cnt_t'(H_SYNC);
    localparam cnt_t VSyncStart = cnt_t'(V_VISIBLE + V_FRONT);
    localparam cnt_t VSyncLen   = cnt_t'(V_SYNC);

    cnt_t        h_cnt_q, h_cnt_d;
    cnt_t        v_cnt_q, v_cnt_d;
    cnt_t        x_q, x_d;
    cnt_t        y_q, y_d;
    logic        active_q, active_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        frame_tick_q, frame_tick_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic [2:0]  rgb_q, rgb_d;
    logic [2:0]  sync_pre;
    logic [2:0]  sync_out;

    // Raster counters: h wraps each line, v steps only on h wrap and wraps at end of frame.
    always_comb begin
        h_cnt_d = (h_cnt_q == HLast) ? '0 : h_cnt_q + cnt_t'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == HLast) begin
            v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + cnt_t'(1);
        end
    end

    // Decode the position being entered so the registered outputs describe the current counters.
    always_comb begin
        active_d      = (h_cnt_d < HVis) && (v_cnt_d < VVis);
        x_d           = active_d ? h_cnt_d + cnt_t'(1) : '0;
        y_d           = active_d ? v_cnt_d + cnt_t'(1) : '0;
        hsync_d       = !in_window(h_cnt_d, HSyncStart, HSyncLen);
        vsync_d       = !in_window(v_cnt_d, VSyncStart, VSyncLen);
        frame_tick_d  = (h_cnt_d == '0) && (v_cnt_d == VVis);
        frame_count_d = frame_tick_d ? frame_count_q + 16'd1 : frame_count_q;
        // Gate with the active bit that lands on the blank_n pin on this same edge.
        rgb_d         = sync_pre[2] ? color : 3'b000;
    end

    // State and presented-position registers; reset parks on the last blanked pixel.
    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            h_cnt_q       <= HLast;
            v_cnt_q       <= VLast;
            x_q           <= '0;
            y_q           <= '0;
            active_q      <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_tick_q  <= 1'b0;
            frame_count_q <= '0;
            rgb_q         <= 3'b000;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            x_q           <= x_d;
            y_q           <= y_d;
            active_q      <= active_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_tick_q  <= frame_tick_d;
            frame_count_q <= frame_count_d;
            rgb_q         <= rgb_d;
        end
    end

    vga_sync_delay #(
        .Depth (Depth)
    ) u_sync_delay (
        .clk_i      (CLOCK_25),
        .rst_ni     (RESET_N),
        .sync_i     ({active_q, hsync_q, vsync_q}),
        .sync_pre_o (sync_pre),
        .sync_o     (sync_out)
    );

    assign x           = x_q;
    assign y           = y_q;
    assign active      = active_q;
    assign frame_tick  = frame_tick_q;
    assign frame_count = frame_count_q;
    assign vga_rgb     = rgb_q;
    assign vga_blank_n = sync_out[2];
    assign vga_hsync   = sync_out[1];
    assign vga_vsync   = sync_out[0];

endmodule

// File: tb/tb_vga_timing_generator.sv
// Self-checking bench: scaled-down raster, arithmetic reference model, key-edge table, async resets.
module tb_vga_timing_generator;

    localparam int HV = 20, HF = 3, HS = 5, HB = 4;
    localparam int VV = 8, VF = 2, VS = 2, VB = 3;
    localparam int CL = 1;
    localparam int HT = HV + HF + HS + HB;   // 32
    localparam int VT = VV + VF + VS + VB;   // 15
    localparam int FRAME = HT * VT;          // 480
    localparam int D = CL + 1;

    logic        CLOCK_25 = 1'b0;
    logic        RESET_N = 1'b1;
    logic [11:0] x, y;
    logic        active;
    logic [2:0]  color;
    logic [2:0]  vga_rgb;
    logic        vga_hsync, vga_vsync, vga_blank_n, frame_tick;
    logic [15:0] frame_count;

    vga_timing_generator #(
        .H_VISIBLE     (HV),
        .H_FRONT       (HF),
        .H_SYNC        (HS),
        .H_BACK        (HB),
        .V_VISIBLE     (VV),
        .V_FRONT       (VF),
        .V_SYNC        (VS),
        .V_BACK        (VB),
        .COLOR_LATENCY (CL)
    ) dut (
        .CLOCK_25    (CLOCK_25),
        .RESET_N     (RESET_N),
        .x           (x),
        .y           (y),
        .active      (active),
        .color       (color),
        .vga_rgb     (vga_rgb),
        .vga_hsync   (vga_hsync),
        .vga_vsync   (vga_vsync),
        .vga_blank_n (vga_blank_n),
        .frame_tick  (frame_tick),
        .frame_count (frame_count)
    );

    always #5 CLOCK_25 = ~CLOCK_25;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        act;
        logic [2:0]  rgb;
        logic        hs;
        logic        vs;
        logic        bn;
        logic        tick;
        logic [15:0] fc;
    } outs_t;

    typedef struct packed {
        logic [31:0] edge_n;
        logic [11:0] x;
        logic [11:0] y;
        logic        act;
        logic        hs;
        logic        vs;
        logic        bn;
        logic        tick;
        logic [15:0] fc;
    } vec_t;

    localparam int NTAB = 17;
    vec_t tab [NTAB];
    bit   hit [NTAB];
    bit   tab_en = 1'b0;

    int checks = 0;
    int failures = 0;
    int edge_n = 0;

    // Image-generator model: colour for x appears one clock later; 111 when blanked.
    logic [2:0] lut [0:HV];
    logic [2:0] pend;

    initial begin
        pend  = 3'b111;
        color = 3'b111;
        forever begin
            @(negedge CLOCK_25);
            color = pend;
            if (x == 12'd0 || int'(x) > HV) pend = 3'b111;
            else pend = lut[int'(x)];
        end
    end

    // Reference: outputs after edge n since reset release, from raster arithmetic.
    function automatic outs_t model(input int n);
        outs_t o;
        int p, h, v;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        if (n >= 1) begin
            p = (n - 1) % FRAME;
            h = p % HT;
            v = p / HT;
            o.act  = (h < HV) && (v < VV);
            o.x    = o.act ? 12'(h + 1) : 12'd0;
            o.y    = o.act ? 12'(v + 1) : 12'd0;
            o.tick = (h == 0) && (v == VV);
            o.fc   = (n - 1 >= VV * HT) ? 16'((n - 1 - VV * HT) / FRAME + 1) : 16'd0;
        end
        if (n - D >= 1) begin
            p = (n - D - 1) % FRAME;
            h = p % HT;
            v = p / HT;
            o.bn = (h < HV) && (v < VV);
            o.hs = !((h >= HV + HF) && (h < HV + HF + HS));
            o.vs = !((v >= VV + VF) && (v < VV + VF + VS));
            if (o.bn) o.rgb = lut[h + 1];
        end
        return o;
    endfunction

    function automatic outs_t sample();
        outs_t a;
        a.x    = x;
        a.y    = y;
        a.act  = active;
        a.rgb  = vga_rgb;
        a.hs   = vga_hsync;
        a.vs   = vga_vsync;
        a.bn   = vga_blank_n;
        a.tick = frame_tick;
        a.fc   = frame_count;
        return a;
    endfunction

    task automatic check_model(input string tag);
        outs_t a, e;
        a = sample();
        e = model(edge_n);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s edge=%0d got x=%0d y=%0d act=%b rgb=%b hs=%b vs=%b bn=%b tick=%b fc=%0d want x=%0d y=%0d act=%b rgb=%b hs=%b vs=%b bn=%b tick=%b fc=%0d",
                     tag, edge_n, a.x, a.y, a.act, a.rgb, a.hs, a.vs, a.bn, a.tick, a.fc,
                     e.x, e.y, e.act, e.rgb, e.hs, e.vs, e.bn, e.tick, e.fc);
        end
    endtask

    task automatic check_table();
        vec_t a;
        for (int k = 0; k < NTAB; k++) begin
            if (tab_en && int'(tab[k].edge_n) == edge_n) begin
                a = '{32'(edge_n), x, y, active, vga_hsync, vga_vsync, vga_blank_n, frame_tick,
                      frame_count};
                hit[k] = 1'b1;
                checks++;
                if (a !== tab[k]) begin
                    failures++;
                    $display("FAIL table edge=%0d got %h want %h", edge_n, a, tab[k]);
                end
            end
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLOCK_25);
            edge_n++;
            @(negedge CLOCK_25);
            check_model("cycle");
            check_table();
        end
    endtask

    // Assert reset offs time units from now (never on an edge), check at once, hold, release.
    task automatic async_reset(input int offs, input bit rand_lut);
        #(offs);
        RESET_N = 1'b0;
        edge_n = 0;
        #1;
        check_model("async_reset_immediate");
        if (rand_lut) begin
            for (int i = 0; i <= HV; i++) lut[i] = 3'($urandom);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLOCK_25);
            check_model("in_reset");
        end
        @(posedge CLOCK_25);
        #2;
        RESET_N = 1'b1;
    endtask

    initial begin
        bit found;
        // edge, x, y, act, hs, vs, bn, tick, fc
        tab[0]  = '{32'd1,   12'd1,  12'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        tab[1]  = '{32'd2,   12'd2,  12'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        tab[2]  = '{32'd3,   12'd3,  12'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0};
        tab[3]  = '{32'd20,  12'd20, 12'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0};
        tab[4]  = '{32'd21,  12'd0,  12'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0};
        tab[5]  = '{32'd23,  12'd0,  12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        tab[6]  = '{32'd26,  12'd0,  12'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        tab[7]  = '{32'd30,  12'd0,  12'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        tab[8]  = '{32'd31,  12'd0,  12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        tab[9]  = '{32'd33,  12'd1,  12'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        tab[10] = '{32'd257, 12'd0,  12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1};
        tab[11] = '{32'd258, 12'd0,  12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1};
        tab[12] = '{32'd322, 12'd0,  12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1};
        tab[13] = '{32'd323, 12'd0,  12'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
        tab[14] = '{32'd386, 12'd0,  12'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
        tab[15] = '{32'd387, 12'd0,  12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1};
        tab[16] = '{32'd481, 12'd1,  12'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1};
        for (int k = 0; k < NTAB; k++) hit[k] = 1'b0;
        for (int i = 0; i <= HV; i++) lut[i] = 3'(i);

        // Power-on reset, checked while held.
        #1;
        RESET_N = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLOCK_25);
            check_model("power_on_reset");
        end
        @(posedge CLOCK_25);
        #2;
        RESET_N = 1'b1;

        // Two frames plus: table edges and full model comparison each cycle.
        tab_en = 1'b1;
        run_cycles(2 * FRAME - 160);
        tab_en = 1'b0;
        checks++;
        if (frame_count !== 16'd2 || !hit[NTAB-1]) begin
            failures++;
            $display("FAIL second_tick fc got %0d want 2", frame_count);
        end
        for (int k = 0; k < NTAB; k++) begin
            if (!hit[k]) begin
                checks++;
                failures++;
                $display("FAIL table_unreached edge=%0d got unreached want reached", tab[k].edge_n);
            end
        end

        // Mid-line async reset at x == HV/2, bounded search.
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            run_cycles(1);
            if (x == 12'(HV / 2)) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL find_mid_line got timeout want x=%0d", HV / 2);
        end
        async_reset(2, 1'b0);
        run_cycles(FRAME + 40);

        // Randomised run lengths, colour tables and reset phases.
        for (int s = 0; s < 4; s++) begin
            run_cycles(int'($urandom_range(50, 1500)));
            @(posedge CLOCK_25);
            edge_n++;
            async_reset(int'($urandom_range(1, 3)), 1'b1);
        end
        run_cycles(FRAME + 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
